seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Consumer end of the clock's digit interface. Takes four BCD digits (hours tens, hours units, minutes tens, minutes units) and time-multiplexes them onto the board's 8-digit common-anode seven-segment display. Brightness is set by an 8-bit PWM value. A guard interval between digits prevents ghosting. Sits between the time-keeping logic and the display pins.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot; 1 ms at 100 MHz, so a 4-digit frame repeats at 250 Hz; must be greater than GUARD_CYC+1.
GUARD_CYC, 100, cycles at the start of each slot with all anodes off.

Ports:
CLK100MHZ  in  1  system clock; all logic on the rising edge.
Reset  in  1  synchronous, active-high reset.
BCD3  in  4  hours tens digit; shown on anode 3.
BCD2  in  4  hours units digit; shown on anode 2.
BCD1  in  4  minutes tens digit; shown on anode 1.
BCD0  in  4  minutes units digit; shown on anode 0.
PWM  in  8  brightness: 0 = dark, 255 = 255/256 duty.
SegmentDrivers  out  8  anodes, active-low; bit n selects digit n.
SevenSegment  out  8  cathodes, active-low; [6:0] = {g,f,e,d,c,b,a}, [7] = DP.

Behaviour:
- Reset, sampled on a clock edge, sets the following on that edge:
  - SegmentDrivers = 8'hFF and SevenSegment = 8'hFF.
  - Slot counter, digit index, PWM counter and all four snapshot registers = 0.
- Reset asserted mid-scan aborts the current slot immediately. The first slot after Reset releases is digit 0 with a fresh guard interval.
- Slot counter runs 0..SCAN_DIV-1 and then wraps to 0. On each wrap the digit index advances 0→1→2→3→0.
- Snapshot: when the slot counter is 0 and the digit index is 0, BCD3..BCD0 are registered. Digits change only on frame boundaries, so there is no tearing. An input change mid-frame appears at the next frame.
- Per-slot state machine:
  - GUARD: slot count < GUARD_CYC. All anodes off, SevenSegment = 8'hFF.
  - DRIVE: slot count ≥ GUARD_CYC. The selected anode is driven low only while PWM counter < PWM; otherwise all anodes stay off.
  - GUARD→DRIVE occurs at count == GUARD_CYC. DRIVE→GUARD occurs on the slot wrap.
- PWM counter: 8-bit, free-running, wraps 255→0. PWM is sampled live, not snapshotted.
  - PWM = 0: display always dark.
  - PWM = 255: display dark for 1 of every 256 cycles.
- Anodes 7..4 are always 1.
- Decode, active-low [6:0], as hex values:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - 10..15 = 7F (blank, not an error).
- DP (SevenSegment[7]) is 0 only while digit 2 is driven; this is the hours:minutes separator. It is 1 in all other cases.
- While the anodes are off, SevenSegment = 8'hFF.
- Latency: SegmentDrivers and SevenSegment are registered, one cycle after the counter state that selects them. Both update on the same edge, so anode and cathode values never mismatch.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: when the snapshotted BCD3 == 0, digit 3 is blank: SevenSegment = 8'hFF and its anode stays off during its DRIVE phase. Scan timing is unchanged.
- Undefined: digit 3 shows "0" normally.

Test Plan:
All tests use SCAN_DIV=16 and GUARD_CYC=2.
- Reset held 3 cycles with PWM=255 → SegmentDrivers=FF and SevenSegment=FF throughout. After release, the first anode-low value is FE, appearing after the 2 guard cycles plus 1 register cycle.
- BCD3..0 = 1,2,3,4, PWM=255, one full frame → digit 0 shows 19, digit 1 shows 30, digit 2 shows 24 with DP=0 (SevenSegment=24), digit 3 shows 79. Anodes follow FE, FD, FB, F7. Each slot is 16 cycles with the first 2 blank.
- PWM=0 for 256 cycles → SegmentDrivers stays FF. PWM=128 over 256 cycles in DRIVE → the anode is low for exactly 128 cycles of the PWM period.
- Change BCD0 from 5 to 6 mid-frame (digit index 2) → digit 0 shows 12 for the rest of this frame and 02 from the next frame.
- BCD1=12 → digit 1 shows SevenSegment=FF while its anode is low. Reset asserted during digit 3's DRIVE → outputs are FF on the next edge, and the scan restarts at digit 0.
- With LEADING_ZERO_BLANK_EN and BCD3=0 → anode 3 is never low. With BCD3=2 → anode 3 is driven and shows 24.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Purpose: time-multiplexes four snapshotted BCD digits onto an 8-digit common-anode display with PWM dimming.
// Latency: anodes and cathodes are registered together, one cycle after the slot/digit/PWM counter state that selects them.
// Backpressure: none; the scan is free-running. Optional macro LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int GUARD_CYC = 100
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic [3:0] BCD3,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD0,
    input  logic [7:0] PWM,
    output logic [7:0] SegmentDrivers,
    output logic [7:0] SevenSegment
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYC);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // A zero-length guard means a slot starts directly in DRIVE.
    localparam state_t ST_SLOT_START = (GUARD_CYC == 0) ? ST_DRIVE : ST_GUARD;

    logic [CW-1:0] r_slot_cnt;
    logic [1:0]    r_digit;
    logic [7:0]    r_pwm_cnt;
    logic [3:0]    r_snap [4];
    state_t        r_state;
    logic [7:0]    r_seg_drv;
    logic [7:0]    r_seven;

    logic          w_wrap;
    logic [CW-1:0] w_slot_nxt;
    state_t        w_state_nxt;
    logic [3:0]    w_bcd_sel;
    logic [6:0]    w_seg7;
    logic          w_dp;
    logic          w_blank;
    logic          w_anode_on;
    logic [7:0]    w_an_nxt;
    logic [7:0]    w_seg_nxt;

    assign w_wrap     = (r_slot_cnt == SLOT_LAST);
    assign w_slot_nxt = w_wrap ? '0 : r_slot_cnt + 1'b1;

    // Slot counter, digit index and free-running PWM counter.
    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            r_slot_cnt <= '0;
            r_digit    <= 2'd0;
            r_pwm_cnt  <= 8'd0;
        end else begin
            r_slot_cnt <= w_slot_nxt;
            r_pwm_cnt  <= r_pwm_cnt + 8'd1;
            if (w_wrap) begin
                r_digit <= r_digit + 2'd1;
            end
        end
    end

    // Capture all four digits once per frame so a frame never mixes old and new time.
    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                r_snap[i] <= 4'd0;
            end
        end else if ((r_slot_cnt == '0) && (r_digit == 2'd0)) begin
            r_snap[0] <= BCD0;
            r_snap[1] <= BCD1;
            r_snap[2] <= BCD2;
            r_snap[3] <= BCD3;
        end
    end

    // Per-slot phase register.
    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            r_state <= ST_SLOT_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Phase sequencing: anodes stay off for the first GUARD_CYC cycles of every slot.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_GUARD: if (w_slot_nxt == GUARD_END) w_state_nxt = ST_DRIVE;
            ST_DRIVE: if (w_wrap)                  w_state_nxt = ST_SLOT_START;
            default:                               w_state_nxt = ST_GUARD;
        endcase
    end

    // Digit select, BCD decode, DP separator and PWM gating for the next output values.
    always_comb begin
        w_bcd_sel = r_snap[r_digit];
        w_dp      = (r_digit == 2'd2) ? 1'b0 : 1'b1;
        case (w_bcd_sel)
            4'd0:    w_seg7 = 7'h40;
            4'd1:    w_seg7 = 7'h79;
            4'd2:    w_seg7 = 7'h24;
            4'd3:    w_seg7 = 7'h30;
            4'd4:    w_seg7 = 7'h19;
            4'd5:    w_seg7 = 7'h12;
            4'd6:    w_seg7 = 7'h02;
            4'd7:    w_seg7 = 7'h78;
            4'd8:    w_seg7 = 7'h00;
            4'd9:    w_seg7 = 7'h10;
            default: w_seg7 = 7'h7F;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (r_digit == 2'd3) && (r_snap[3] == 4'd0);
`else
        w_blank = 1'b0;
`endif
        w_anode_on = (r_state == ST_DRIVE) && (r_pwm_cnt < PWM) && !w_blank;
        w_an_nxt   = 8'hFF;
        w_seg_nxt  = 8'hFF;
        if (w_anode_on) begin
            w_an_nxt  = {4'hF, ~(4'b0001 << r_digit)};
            w_seg_nxt = {w_dp, w_seg7};
        end
    end

    // Anodes and cathodes share one register stage so they always change together.
    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            r_seg_drv <= 8'hFF;
            r_seven   <= 8'hFF;
        end else begin
            r_seg_drv <= w_an_nxt;
            r_seven   <= w_seg_nxt;
        end
    end

    assign SegmentDrivers = r_seg_drv;
    assign SevenSegment   = r_seven;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Purpose: self-checking bench for seg_scan_driver with a short scan (16-cycle slots, 2 guard cycles).
// Latency: expected outputs are queued before each edge and compared at the following negedge.
// Backpressure: none; the bench steps the free-running scan one clock at a time.
module tb_seg_scan_driver;

    localparam int SD = 16;
    localparam int GC = 2;

    logic       clk = 1'b0;
    logic       Reset;
    logic [3:0] BCD3, BCD2, BCD1, BCD0;
    logic [7:0] PWM;
    logic [7:0] an;
    logic [7:0] seg;

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(SD), .GUARD_CYC(GC)) dut (
        .CLK100MHZ     (clk),
        .Reset         (Reset),
        .BCD3          (BCD3),
        .BCD2          (BCD2),
        .BCD1          (BCD1),
        .BCD0          (BCD0),
        .PWM           (PWM),
        .SegmentDrivers(an),
        .SevenSegment  (seg)
    );

    typedef struct {
        logic [3:0] d;
        logic [6:0] seg;
    } dec_vec_t;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;

    dec_vec_t   dec_tab [16];
    exp_t       sb_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         t = 0;
    logic [3:0] m_snap [4];
    logic [7:0] last_an, last_seg;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Reference: slot, digit and PWM phase all follow from cycles since reset.
    function automatic exp_t model();
        exp_t e;
        int   slot, dig, pc;
        logic blank;
        e.an  = 8'hFF;
        e.seg = 8'hFF;
        slot  = t % SD;
        dig   = (t / SD) % 4;
        pc    = t % 256;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (dig == 3) && (m_snap[3] == 4'd0);
`else
        blank = 1'b0;
`endif
        if (slot >= GC && pc < int'(PWM) && !blank) begin
            e.an[dig] = 1'b0;
            e.seg     = {(dig != 2), dec_tab[m_snap[dig]].seg};
        end
        return e;
    endfunction

    task automatic step();
        exp_t e, g;
        if (Reset) begin
            e.an  = 8'hFF;
            e.seg = 8'hFF;
        end else begin
            e = model();
        end
        sb_q.push_back(e);
        if (Reset) begin
            t = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
        end else begin
            if (t % (SD * 4) == 0) begin
                m_snap[0] = BCD0;
                m_snap[1] = BCD1;
                m_snap[2] = BCD2;
                m_snap[3] = BCD3;
            end
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        g        = sb_q.pop_front();
        last_an  = an;
        last_seg = seg;
        check("scoreboard", {an, seg}, {g.an, g.seg});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the output for model time tgt-1 has been observed.
    task automatic run_until(input int tgt);
        int guard_cnt;
        guard_cnt = 0;
        while (t != tgt && guard_cnt < 5000) begin
            step();
            guard_cnt++;
        end
        check("run_until_reached", 16'(t), 16'(tgt));
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    logic [7:0] frm_an  [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    logic [7:0] frm_seg [4] = '{8'h99, 8'hB0, 8'h24, 8'hF9};

    initial begin
        int k, cnt;

        dec_tab[0] = '{4'd0, 7'h40};
        dec_tab[1] = '{4'd1, 7'h79};
        dec_tab[2] = '{4'd2, 7'h24};
        dec_tab[3] = '{4'd3, 7'h30};
        dec_tab[4] = '{4'd4, 7'h19};
        dec_tab[5] = '{4'd5, 7'h12};
        dec_tab[6] = '{4'd6, 7'h02};
        dec_tab[7] = '{4'd7, 7'h78};
        dec_tab[8] = '{4'd8, 7'h00};
        dec_tab[9] = '{4'd9, 7'h10};
        for (int i = 10; i < 16; i++) dec_tab[i] = '{4'(i), 7'h7F};
        for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;

        Reset = 1'b1;
        BCD3 = 4'd0; BCD2 = 4'd0; BCD1 = 4'd0; BCD0 = 4'd0;
        PWM  = 8'd255;

        // Reset held 3 cycles: everything dark.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_an", {8'h00, last_an}, 16'h00FF);
            check("reset_seg", {8'h00, last_seg}, 16'h00FF);
        end
        Reset = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (last_an == 8'hFF && k < 8);
        check("first_drive_latency", 16'(k), 16'd3);
        check("first_drive_anode", {8'h00, last_an}, 16'h00FE);

        // Decode table: each value shown on digit 0 right after the guard.
        for (int i = 0; i < 16; i++) begin
            BCD0 = dec_tab[i].d;
            pulse_reset();
            run(3);
            check("dec_anode", {8'h00, last_an}, 16'h00FE);
            check("dec_seg", {8'h00, last_seg}, {8'h00, 1'b1, dec_tab[i].seg});
        end

        // Full frame 1,2,3,4: guard then drive in every slot.
        BCD3 = 4'd1; BCD2 = 4'd2; BCD1 = 4'd3; BCD0 = 4'd4;
        pulse_reset();
        for (int d = 0; d < 4; d++) begin
            run_until(d * SD + 2);
            check("frame_guard", {last_an, last_seg}, 16'hFFFF);
            run_until(d * SD + 6);
            check("frame_anode", {8'h00, last_an}, {8'h00, frm_an[d]});
            check("frame_seg", {8'h00, last_seg}, {8'h00, frm_seg[d]});
        end
        run_until(4 * SD);

        // Brightness: PWM=0 is dark, PWM=128 lights half of each drive phase.
        PWM = 8'd0;
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (last_an != 8'hFF) cnt++;
        end
        check("pwm0_lit_cycles", 16'(cnt), 16'd0);
        PWM = 8'd128;
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (last_an != 8'hFF) cnt++;
        end
        // 8 slots fall under PWM<128, each with 14 drive cycles.
        check("pwm128_lit_cycles", 16'(cnt), 16'd112);

        // Mid-frame BCD0 change is held off until the next frame.
        PWM = 8'd255;
        BCD0 = 4'd5;
        pulse_reset();
        run_until(6);
        check("snap_old_digit0", {9'h000, last_seg[6:0]}, 16'h0012);
        run_until(2 * SD + 3);
        BCD0 = 4'd6;
        run_until(4 * SD + 6);
        check("snap_new_anode", {8'h00, last_an}, 16'h00FE);
        check("snap_new_digit0", {9'h000, last_seg[6:0]}, 16'h0002);

        // Out-of-range BCD blanks the cathodes while the anode is still driven.
        BCD1 = 4'd12;
        pulse_reset();
        run_until(SD + 6);
        check("blank_anode", {8'h00, last_an}, 16'h00FD);
        check("blank_seg", {8'h00, last_seg}, 16'h00FF);

        // Reset during digit 3 drive aborts the slot and restarts at digit 0.
        BCD1 = 4'd3;
        run_until(3 * SD + 8);
        check("pre_abort_anode", {8'h00, last_an}, 16'h00F7);
        pulse_reset();
        check("abort_outputs", {last_an, last_seg}, 16'hFFFF);
        run_until(2);
        check("restart_guard", {last_an, last_seg}, 16'hFFFF);
        run_until(3);
        check("restart_digit0", {8'h00, last_an}, 16'h00FE);

        // Leading zero on the hours tens digit.
        BCD3 = 4'd0;
        pulse_reset();
        cnt = 0;
        for (int i = 0; i < 4 * SD; i++) begin
            step();
            if (last_an[3] == 1'b0) cnt++;
        end
`ifdef LEADING_ZERO_BLANK_EN
        check("lzb_anode3_lit", 16'(cnt), 16'd0);
`else
        check("lzb_anode3_lit", 16'(cnt), 16'd14);
`endif
        BCD3 = 4'd2;
        pulse_reset();
        run_until(3 * SD + 6);
        check("digit3_anode", {8'h00, last_an}, 16'h00F7);
        check("digit3_seg", {8'h00, last_seg}, 16'h00A4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
